// File: rtl/toggle_monitor.sv
// toggle_monitor: synchronizes a latch toggle level into the clk domain,
// counts every toggle, pulses on reaching a threshold and offers a count
// snapshot over a valid/ready port.
//
// Handshake: rd_valid/rd_data form a strict valid/ready source. Once rd_valid
// is high, rd_data stays stable until an edge where rd_valid & rd_ready are
// both 1; that edge completes the transfer. rd_valid never depends
// combinationally on rd_ready, and rd_ready is ignored while rd_valid is low.
// rd_valid is a direct decode of the FSM state (HOLD), so it doubles as the
// observable state of the snapshot FSM.
module toggle_monitor #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             clear,
  input  logic [WIDTH-1:0] threshold,
  output logic             rise,
  output logic             fall,
  output logic [WIDTH-1:0] count,
  output logic             match,
  output logic             overflow,
  output logic             dropped,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready
);

  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   q_dly_q, q_dly_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [WIDTH-1:0]       count_q, count_d;
  logic                   match_q, match_d;
  logic                   overflow_q, overflow_d;
  logic                   dropped_q, dropped_d;
  logic [WIDTH-1:0]       rd_data_q, rd_data_d;
  state_t                 state_q, state_d;

  logic                   q_s;
  logic                   toggle;
  logic                   wrap;
  logic                   hit;
  logic [WIDTH-1:0]       cnt_inc;

  assign q_s     = sync_q[SYNC_STAGES-1];
  assign toggle  = q_s ^ q_dly_q;
  assign cnt_inc = count_q + 1'b1;
  assign wrap    = toggle && (count_q == {WIDTH{1'b1}});
  // A clear in the same cycle discards the toggle, so it cannot match either.
  assign hit     = toggle && !clear && (cnt_inc == threshold);

  // Synchronizer chain, edge detect, counter and sticky status.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], q_in};
    q_dly_d    = q_s;
    rise_d     = q_s & ~q_dly_q;
    fall_d     = ~q_s & q_dly_q;
    count_d    = toggle ? cnt_inc : count_q;
    overflow_d = overflow_q | wrap;
    match_d    = hit;
    if (clear) begin
      // The synchronizer and q_dly keep running so the discarded toggle is
      // not re-detected on the following cycle.
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      count_d    = '0;
      overflow_d = 1'b0;
      match_d    = 1'b0;
    end
  end

  // Snapshot FSM: next state, snapshot data and lost-match flag.
  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    dropped_d = dropped_q;
    case (state_q)
      ST_COUNT: begin
        if (hit) begin
          rd_data_d = cnt_inc;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (rd_ready) begin
          // Transfer completes; a coincident match reloads immediately.
          if (hit) begin
            rd_data_d = cnt_inc;
          end else begin
            state_d = ST_COUNT;
          end
        end else if (hit) begin
          dropped_d = 1'b1;
        end
      end
      default: state_d = ST_COUNT;
    endcase
    if (clear) begin
      state_d   = ST_COUNT;
      dropped_d = 1'b0;
    end
  end

  // State register; rst has priority over clear and counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      q_dly_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      count_q    <= '0;
      match_q    <= 1'b0;
      overflow_q <= 1'b0;
      dropped_q  <= 1'b0;
      rd_data_q  <= '0;
      state_q    <= ST_COUNT;
    end else begin
      sync_q     <= sync_d;
      q_dly_q    <= q_dly_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      count_q    <= count_d;
      match_q    <= match_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
      rd_data_q  <= rd_data_d;
      state_q    <= state_d;
    end
  end

  assign rise     = rise_q;
  assign fall     = fall_q;
  assign count    = count_q;
  assign match    = match_q;
  assign overflow = overflow_q;
  assign dropped  = dropped_q;
  assign rd_valid = (state_q == ST_HOLD);
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_toggle_monitor.sv
// Directed bench for toggle_monitor (WIDTH=8, SYNC_STAGES=2).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, so every observation reflects the edge just taken.
module tb_toggle_monitor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         q_in;
  logic         clear;
  logic [W-1:0] threshold;
  logic         rise;
  logic         fall;
  logic [W-1:0] count;
  logic         match;
  logic         overflow;
  logic         dropped;
  logic         rd_valid;
  logic [W-1:0] rd_data;
  logic         rd_ready;

  int checks = 0;
  int errors = 0;

  toggle_monitor #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .q_in      (q_in),
    .clear     (clear),
    .threshold (threshold),
    .rise      (rise),
    .fall      (fall),
    .count     (count),
    .match     (match),
    .overflow  (overflow),
    .dropped   (dropped),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready)
  );

  // Clock and reset-free clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Flip q_in and wait until the resulting count update is visible.
  task automatic toggle_settle();
    q_in = ~q_in;
    ticks(3);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int match_cnt;
  int valid_cyc;
  logic [W-1:0] snap;

  initial begin
    rst = 1'b1; q_in = 1'b0; clear = 1'b0; threshold = 8'd200; rd_ready = 1'b0;
    ticks(2);
    rst = 1'b0;

    // Reset state and quiet input
    check("rst_count", 32'(count), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    ticks(10);
    check("idle_count", 32'(count), 32'd0);
    check("idle_edges", 32'({rise, fall, match}), 32'd0);
    check("idle_status", 32'({overflow, dropped, rd_valid}), 32'd0);

    // Latency: q_in sampled at edge N, pulse after edge N+2
    q_in = 1'b1;
    tick();
    check("lat_n_rise", 32'(rise), 32'd0);
    tick();
    check("lat_n1_rise", 32'(rise), 32'd0);
    check("lat_n1_count", 32'(count), 32'd0);
    tick();
    check("lat_n2_rise", 32'(rise), 32'd1);
    check("lat_n2_count", 32'(count), 32'd1);
    tick();
    check("rise_one_cycle", 32'(rise), 32'd0);
    q_in = 1'b0;
    ticks(3);
    check("fall_pulse", 32'(fall), 32'd1);
    check("fall_no_rise", 32'(rise), 32'd0);
    check("fall_count", 32'(count), 32'd2);
    tick();
    check("fall_one_cycle", 32'(fall), 32'd0);

    // threshold=4, six fast toggles, rd_ready=1
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_count", 32'(count), 32'd0);
    threshold = 8'd4; rd_ready = 1'b1;
    match_cnt = 0; valid_cyc = 0; snap = '0;
    for (int i = 0; i < 14; i++) begin
      if (i < 6) q_in = ~q_in;
      tick();
      if (match) begin
        match_cnt++;
        check("t4_match_at_4", 32'(count), 32'd4);
      end
      if (rd_valid) begin
        valid_cyc++;
        snap = rd_data;
      end
    end
    check("t4_match_cnt", 32'(match_cnt), 32'd1);
    check("t4_valid_cycles", 32'(valid_cyc), 32'd1);
    check("t4_snap", 32'(snap), 32'd4);
    check("t4_dropped", 32'(dropped), 32'd0);
    check("t4_count", 32'(count), 32'd6);

    // threshold=2, rd_ready=0: snapshot holds until clear
    clear = 1'b1; tick(); clear = 1'b0;
    threshold = 8'd2; rd_ready = 1'b0;
    toggle_settle();
    check("t2_no_valid_yet", 32'(rd_valid), 32'd0);
    toggle_settle();
    check("t2_match", 32'(match), 32'd1);
    check("t2_valid", 32'(rd_valid), 32'd1);
    check("t2_data", 32'(rd_data), 32'd2);
    toggle_settle();
    check("t2_hold_count", 32'(count), 32'd3);
    check("t2_hold_valid", 32'(rd_valid), 32'd1);
    check("t2_hold_data", 32'(rd_data), 32'd2);
    clear = 1'b1; tick(); clear = 1'b0;
    check("t2_clr_valid", 32'(rd_valid), 32'd0);
    check("t2_clr_count", 32'(count), 32'd0);
    toggle_settle();
    toggle_settle();
    check("t2_again_valid", 32'(rd_valid), 32'd1);
    check("t2_again_data", 32'(rd_data), 32'd2);
    check("t2_again_dropped", 32'(dropped), 32'd0);

    // Wrap back onto 2 while the snapshot is still pending
    for (int i = 0; i < 256; i++) begin
      q_in = ~q_in;
      tick();
    end
    ticks(3);
    check("wrap_count", 32'(count), 32'd2);
    check("wrap_dropped", 32'(dropped), 32'd1);
    check("wrap_data", 32'(rd_data), 32'd2);
    check("wrap_overflow", 32'(overflow), 32'd1);
    ticks(5);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("drop_sticky", 32'(dropped), 32'd1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_status", 32'({overflow, dropped, rd_valid}), 32'd0);

    // threshold=0 matches only on the 255->0 wrap
    threshold = 8'd0; rd_ready = 1'b1; match_cnt = 0;
    for (int i = 0; i < 255; i++) begin
      q_in = ~q_in;
      tick();
      if (match) match_cnt++;
    end
    ticks(3);
    check("t0_count_255", 32'(count), 32'd255);
    check("t0_no_match", 32'(match_cnt), 32'd0);
    check("t0_no_ovf", 32'(overflow), 32'd0);
    toggle_settle();
    check("t0_wrap_count", 32'(count), 32'd0);
    check("t0_wrap_ovf", 32'(overflow), 32'd1);
    check("t0_wrap_match", 32'(match), 32'd1);
    check("t0_wrap_data", 32'(rd_data), 32'd0);

    // Clear coincident with a toggle: toggle discarded, not re-detected
    clear = 1'b1; tick(); clear = 1'b0;
    threshold = 8'd200; rd_ready = 1'b0;
    q_in = ~q_in;
    ticks(2);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_toggle_count", 32'(count), 32'd0);
    check("clr_toggle_edges", 32'({rise, fall}), 32'd0);
    ticks(2);
    check("clr_toggle_later", 32'(count), 32'd0);

    // Match coincident with a completing transfer
    threshold = 8'd1;
    toggle_settle();
    check("co_first_valid", 32'(rd_valid), 32'd1);
    check("co_first_data", 32'(rd_data), 32'd1);
    threshold = 8'd3;
    toggle_settle();
    check("co_count2", 32'(count), 32'd2);
    q_in = ~q_in;
    ticks(2);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("co_match", 32'(match), 32'd1);
    check("co_valid", 32'(rd_valid), 32'd1);
    check("co_data", 32'(rd_data), 32'd3);
    check("co_dropped", 32'(dropped), 32'd0);
    tick();
    check("co_still_valid", 32'(rd_valid), 32'd1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("co_drained", 32'(rd_valid), 32'd0);

    // Reset asserted while a snapshot is pending
    threshold = 8'd4;
    toggle_settle();
    check("hold_before_rst", 32'(rd_valid), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_hold_valid", 32'(rd_valid), 32'd0);
    check("rst_hold_count", 32'(count), 32'd0);
    check("rst_hold_data", 32'(rd_data), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
